// File: rtl/mux_arb_pkg.sv
// Shared definitions for the N-to-1 result selector.
// MODE encodings used by the top level and the bench.
package mux_arb_pkg;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_RR     = 1'b1;

endpackage

// File: rtl/rr_pick_nb.sv
// Round-robin pick: first set REQ bit at or after PTR, wrapping mod N.
// Ports: REQ, PTR in; FOUND, IDX out. Purely combinational.
module rr_pick_nb
  import mux_arb_pkg::*;
#(
  parameter  int N    = 5,
  localparam int SELW = $clog2(N)
) (
  input  logic [N-1:0]    REQ,
  input  logic [SELW-1:0] PTR,
  output logic            FOUND,
  output logic [SELW-1:0] IDX
);

  int c;

  // Walk offsets from farthest to nearest so the nearest hit wins.
  always_comb begin
    FOUND = 1'b0;
    IDX   = '0;
    c     = 0;
    for (int k = N - 1; k >= 0; k--) begin
      c = int'(PTR) + k;
      if (c >= N) c = c - N;
      if (REQ[c]) begin
        FOUND = 1'b1;
        IDX   = SELW'(c);
      end
    end
  end

endmodule

// File: rtl/mux_arb_nt1_nb.sv
// N-to-1 result selector: direct or round-robin grant, one-entry output reg.
// Ports: CLK, RST, MODE, SEL, D_IN/D_VLD/D_RDY in, D_OUT/OUT_VLD/OUT_SRC/OUT_RDY out.
module mux_arb_nt1_nb
  import mux_arb_pkg::*;
#(
  parameter  int N    = 5,
  parameter  int W    = 32,
  localparam int SELW = $clog2(N)
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            MODE,
  input  logic [SELW-1:0] SEL,
  input  logic [N*W-1:0]  D_IN,
  input  logic [N-1:0]    D_VLD,
  output logic [N-1:0]    D_RDY,
  output logic [W-1:0]    D_OUT,
  output logic            OUT_VLD,
  input  logic            OUT_RDY,
  output logic [SELW-1:0] OUT_SRC
);

  localparam logic [SELW:0]   N_L  = (SELW + 1)'(N);
  localparam logic [SELW-1:0] LAST = SELW'(N - 1);

  logic [W-1:0]    d_out_q, d_out_d;
  logic [SELW-1:0] src_q, src_d;
  logic [SELW-1:0] ptr_q, ptr_d;
  logic            out_vld_q, out_vld_d;

  logic            space;
  logic            rr_found;
  logic [SELW-1:0] rr_idx;
  logic            sel_ok;
  logic            grant_vld;
  logic [SELW-1:0] grant_idx;

  rr_pick_nb #(.N(N)) u_pick (
    .REQ   (D_VLD),
    .PTR   (ptr_q),
    .FOUND (rr_found),
    .IDX   (rr_idx)
  );

  assign space = !out_vld_q || OUT_RDY;

  // Out-of-range SEL simply yields no request.
  always_comb begin
    sel_ok = 1'b0;
    if ({1'b0, SEL} < N_L) sel_ok = D_VLD[SEL];
  end

  // No grant during reset so the input handshake is never accepted.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    if (!RST && space) begin
      if (MODE == MODE_RR) begin
        grant_vld = rr_found;
        grant_idx = rr_idx;
      end else begin
        grant_vld = sel_ok;
        grant_idx = SEL;
      end
    end
  end

  always_comb begin
    D_RDY = '0;
    for (int i = 0; i < N; i++) begin
      D_RDY[i] = grant_vld && (grant_idx == SELW'(i));
    end
  end

  always_comb begin
    d_out_d   = d_out_q;
    src_d     = src_q;
    ptr_d     = ptr_q;
    out_vld_d = out_vld_q;
    if (grant_vld) begin
      d_out_d   = D_IN[int'(grant_idx)*W +: W];
      src_d     = grant_idx;
      out_vld_d = 1'b1;
      if (MODE == MODE_RR) begin
        ptr_d = (grant_idx == LAST) ? '0 : grant_idx + 1'b1;
      end
    end else if (OUT_RDY) begin
      out_vld_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      d_out_q   <= '0;
      src_q     <= '0;
      ptr_q     <= '0;
      out_vld_q <= 1'b0;
    end else begin
      d_out_q   <= d_out_d;
      src_q     <= src_d;
      ptr_q     <= ptr_d;
      out_vld_q <= out_vld_d;
    end
  end

  assign D_OUT   = d_out_q;
  assign OUT_SRC = src_q;
  assign OUT_VLD = out_vld_q;

endmodule

// File: tb/tb_mux_arb_nt1_nb.sv
// Directed bench for mux_arb_nt1_nb (N=5, W=32).
// Inputs change #1 after the rising edge; outputs are checked #1 later.
module tb_mux_arb_nt1_nb;
  import mux_arb_pkg::*;

  localparam int N = 5;
  localparam int W = 32;
  localparam int SELW = $clog2(N);

  logic            clk = 1'b0;
  logic            rst;
  logic            mode;
  logic [SELW-1:0] sel;
  logic [N*W-1:0]  d_in;
  logic [N-1:0]    d_vld;
  logic [N-1:0]    d_rdy;
  logic [W-1:0]    d_out;
  logic            out_vld;
  logic            out_rdy;
  logic [SELW-1:0] out_src;

  int n_chk = 0;
  int n_pass = 0;

  mux_arb_nt1_nb #(.N(N), .W(W)) dut (
    .CLK     (clk),
    .RST     (rst),
    .MODE    (mode),
    .SEL     (sel),
    .D_IN    (d_in),
    .D_VLD   (d_vld),
    .D_RDY   (d_rdy),
    .D_OUT   (d_out),
    .OUT_VLD (out_vld),
    .OUT_RDY (out_rdy),
    .OUT_SRC (out_src)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int i, input logic [W-1:0] v);
    d_in[i*W +: W] = v;
  endtask

  task automatic chk_out(input string tag, input logic [31:0] dat,
                         input int src, input logic vld);
    chk({tag, ".vld"}, 32'(out_vld), 32'(vld));
    chk({tag, ".dat"}, d_out, dat);
    chk({tag, ".src"}, 32'(out_src), 32'(src));
  endtask

  initial begin
    rst = 1'b1;
    mode = MODE_RR;
    sel = '0;
    out_rdy = 1'b1;
    d_vld = 5'b11111;
    d_in = '0;
    for (int i = 0; i < N; i++) set_ch(i, 32'h100 + 32'(i));

    // Reset held two cycles with everything valid.
    tick();
    #1;
    chk("rst1.rdy", 32'(d_rdy), 32'h0);
    chk_out("rst1", 32'h0, 0, 1'b0);
    tick();
    #1;
    chk("rst2.rdy", 32'(d_rdy), 32'h0);
    chk_out("rst2", 32'h0, 0, 1'b0);

    // Release in RR: fair rotation, no bubbles.
    rst = 1'b0;
    #1;
    chk("rr.rdy0", 32'(d_rdy), 32'h01);
    for (int k = 0; k < 6; k++) begin
      tick();
      #1;
      chk_out($sformatf("rr%0d", k), 32'h100 + 32'(k % N), k % N, 1'b1);
    end

    // Direct mode, SEL=3.
    mode = MODE_DIRECT;
    sel = 3'd3;
    set_ch(3, 32'hDEADBEEF);
    d_vld = 5'b01000;
    #1;
    chk("dir.rdy", 32'(d_rdy), 32'h08);
    tick();
    #1;
    chk_out("dir", 32'hDEADBEEF, 3, 1'b1);

    // Out-of-range select: no grant, output drains.
    sel = 3'd6;
    #1;
    chk("sel6.rdy", 32'(d_rdy), 32'h0);
    tick();
    #1;
    chk_out("sel6", 32'hDEADBEEF, 3, 1'b0);

    // RR with PTR=1: only ch3 valid -> PTR becomes 4.
    mode = MODE_RR;
    set_ch(3, 32'h103);
    #1;
    chk("p4.rdy", 32'(d_rdy), 32'h08);
    tick();
    // Wrap from PTR=4 to sparse ch1.
    d_vld = 5'b00010;
    #1;
    chk("wrap.rdy", 32'(d_rdy), 32'h02);
    tick();
    #1;
    chk_out("wrap", 32'h101, 1, 1'b1);
    // PTR=2 must prefer ch2 over ch0/ch1.
    set_ch(2, 32'h12);
    d_vld = 5'b00111;
    #1;
    chk("ptr2.rdy", 32'(d_rdy), 32'h04);
    tick();
    #1;
    chk_out("ptr2", 32'h12, 2, 1'b1);

    // Backpressure for three cycles with ch4 waiting.
    out_rdy = 1'b0;
    d_vld = 5'b10000;
    set_ch(4, 32'h44);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("bp%0d.rdy", k), 32'(d_rdy), 32'h0);
      chk_out($sformatf("bp%0d", k), 32'h12, 2, 1'b1);
      tick();
    end
    out_rdy = 1'b1;
    #1;
    chk("bp.rise", 32'(d_rdy), 32'h10);
    tick();
    #1;
    chk_out("bp.load", 32'h44, 4, 1'b1);

    // Mode switch while stalled; PTR=0 but direct picks SEL=1.
    out_rdy = 1'b0;
    mode = MODE_DIRECT;
    sel = 3'd1;
    d_vld = 5'b00011;
    #1;
    chk("ms.rdy", 32'(d_rdy), 32'h0);
    tick();
    #1;
    chk_out("ms.hold", 32'h44, 4, 1'b1);
    out_rdy = 1'b1;
    #1;
    chk("ms.rdy2", 32'(d_rdy), 32'h02);
    tick();
    #1;
    chk_out("ms.load", 32'h101, 1, 1'b1);

    // Reset mid-transfer discards output and blocks the handshake.
    rst = 1'b1;
    mode = MODE_RR;
    d_vld = 5'b11111;
    #1;
    chk("mrst.rdy", 32'(d_rdy), 32'h0);
    tick();
    #1;
    chk_out("mrst", 32'h0, 0, 1'b0);
    rst = 1'b0;
    #1;
    chk("mrst.ptr", 32'(d_rdy), 32'h01);
    tick();
    #1;
    chk_out("mrst.first", 32'h100, 0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mux_arb_nt1_nb.md
# mux_arb_nt1_nb

Parametrised N-to-1 result selector with a registered output stage and per-channel valid/ready handshakes. It succeeds the fixed 5-input combinational result mux on the ALU/writeback path. It adds configurable channel count and width, a round-robin arbitration mode alongside direct SEL-driven selection, and a one-entry output register that holds data under backpressure. It sits between multi-source result producers (ALU, multiplier, CSR, load unit) and the register-file write port.

## Interface

**Parameters**
- `N`, default 5: number of input channels, minimum 2.
- `W`, default 32: data width in bits.
- `SELW`, derived localparam, `$clog2(N)`: width of the select and source fields.

**Ports**
- `CLK`, input, 1 bit: the single clock. All state updates on the rising edge.
- `RST`, input, 1 bit: reset, synchronous and active-high.
- `MODE`, input, 1 bit: 0 = direct (`SEL` chooses the channel); 1 = round-robin arbitration.
- `SEL`, input, `SELW` bits: channel select, used only in direct mode.
- `D_IN`, input, `N*W` bits: packed channel data; channel i occupies `[i*W +: W]`.
- `D_VLD`, input, `N` bits: per-channel valid.
- `D_RDY`, output, `N` bits: per-channel ready. One-hot or zero.
- `D_OUT`, output, `W` bits: registered selected data.
- `OUT_VLD`, output, 1 bit: `D_OUT` holds valid data.
- `OUT_RDY`, input, 1 bit: downstream accepts `D_OUT`.
- `OUT_SRC`, output, `SELW` bits: index of the channel that produced `D_OUT`.

## Operation

- Output stage is a single holding register (`D_OUT`, `OUT_SRC`, `OUT_VLD`).
  - `space = !OUT_VLD | OUT_RDY`.
- Grant (combinational) is computed every cycle.
- Direct mode:
  - `grant = SEL` when `SEL < N`, `D_VLD[SEL] = 1` and `space = 1`.
  - Otherwise no grant.
  - `SEL >= N` never grants and never stalls other logic.
- Round-robin mode:
  - Search starts at channel `PTR` and wraps modulo N.
  - The first i with `D_VLD[i] = 1` is granted when `space = 1`.
- `D_RDY[grant] = 1` and all other bits are 0. With no grant, `D_RDY = 0`.
- Transfer occurs on a cycle where `D_VLD[i] & D_RDY[i]`. At the next edge:
  - `D_OUT <= D_IN[i]`, `OUT_SRC <= i`, `OUT_VLD <= 1`.
- Drain without refill (`OUT_VLD & OUT_RDY`, no grant): `OUT_VLD <= 0`. `D_OUT` and `OUT_SRC` keep their last values.
- Simultaneous drain and refill on one cycle: the new data loads and `OUT_VLD` stays 1. There is no bubble.
- `PTR` update:
  - On a transfer in round-robin mode, `PTR <= (i == N-1) ? 0 : i + 1`.
  - `PTR` is unchanged in direct mode or when no transfer occurs.
- `MODE` or `SEL` changes only affect the next grant. The held output is never modified.
- No data is dropped or duplicated. Each accepted input appears exactly once on the output.

## Timing

- Reset values: `OUT_VLD = 0`, `D_OUT = 0`, `OUT_SRC = 0`, `PTR = 0`. `D_RDY = 0` during the reset cycle.
- `RST` asserted mid-transfer discards the held word. The input handshake on that cycle is not accepted.
- Latency: input accepted at edge k appears on `D_OUT` with `OUT_VLD = 1` after edge k+1.
- Throughput: one word per cycle while `OUT_RDY = 1`.
- Backpressure: while `OUT_VLD & !OUT_RDY`, `D_OUT` and `OUT_SRC` are stable and all `D_RDY` bits are 0.
- `OUT_RDY` feeds `D_RDY` combinationally. Upstream must not make `D_VLD` depend on `D_RDY`.

## Structure

- Shared package `mux_arb_pkg`:
  - `MODE_DIRECT = 1'b0`, `MODE_RR = 1'b1`.
- Sub-module `rr_pick_nb #(N)`:
  - Inputs: `REQ[N-1:0]`, `PTR`.
  - Outputs: `FOUND`, `IDX`.
  - Purely combinational rotate-and-priority-encode.
- The top level contains the grant mux, `D_RDY` decode, the output register and `PTR`.

## Test plan

1. **Reset.** Hold `RST` for 2 cycles with all `D_VLD = 1`. Required: `OUT_VLD = 0`, `D_OUT = 0`, `D_RDY = 0`. Release in RR mode; the first output has `OUT_SRC = 0`.
2. **Direct mode.** N=5, W=32, `SEL = 3`, `D_IN[3] = 0xDEADBEEF`, `D_VLD = 5'b01000`, `OUT_RDY = 1`. Required: `D_RDY = 5'b01000`; next cycle `D_OUT = 0xDEADBEEF`, `OUT_SRC = 3`. Then `SEL = 6`: `D_RDY = 0` and `OUT_VLD` falls.
3. **Round-robin fairness.** `D_VLD = 5'b11111` held, `OUT_RDY = 1`. Required: `OUT_SRC` sequence 0,1,2,3,4,0 on consecutive cycles.
4. **Backpressure.** Output holds channel 2 value `0x12`, `OUT_RDY = 0` for 3 cycles while channel 4 is valid. Required: `D_OUT = 0x12` stable and `D_RDY = 0`. When `OUT_RDY` rises, `D_RDY[4] = 1` the same cycle and `D_OUT = D_IN[4]` next cycle, with no bubble.
5. **Wrap and sparse requests.** RR mode, `PTR = 4`, `D_VLD = 5'b00010`. Required: grant channel 1, then `PTR = 2`.
6. **Mode switch under stall.** Switch `MODE` from 1 to 0 while `OUT_VLD & !OUT_RDY`. Required: held `D_OUT` and `OUT_SRC` are unchanged, and the next grant follows `SEL`.
